// File: rtl/sc_program_loader.sv
// Boot loader for the single-cycle MIPS core: receives a length-prefixed, XOR-checked byte
// stream and writes big-endian words into instruction memory. After that it releases the core.
module sc_program_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int MAX_WORDS  = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_enable,
  output logic                  busy,
  output logic                  error
);

  typedef enum logic [2:0] {
    S_HDR_HI,
    S_HDR_LO,
    S_DATA,
    S_CHK,
    S_RUN,
    S_ERROR
  } state_e;

  localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

  state_e                state_q, state_d;
  logic [15:0]           len_q, len_d;
  logic [ADDR_WIDTH:0]   word_idx_q, word_idx_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic [23:0]           word_buf_q, word_buf_d;
  logic [7:0]            chk_q, chk_d;
  logic                  imem_we_q, imem_we_d;
  logic [ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]           imem_wdata_q, imem_wdata_d;
  logic                  cpu_enable_q, cpu_enable_d;
  logic                  busy_q, busy_d;
  logic                  error_q, error_d;

  logic loading;
  logic accept;

  assign loading  = (state_q == S_HDR_HI) || (state_q == S_HDR_LO) ||
                    (state_q == S_DATA)   || (state_q == S_CHK);
  assign in_ready = loading && !load;
  assign accept   = in_valid && in_ready;

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the case leaves a latch.
    state_d      = state_q;
    len_d        = len_q;
    word_idx_d   = word_idx_q;
    byte_idx_d   = byte_idx_q;
    word_buf_d   = word_buf_q;
    chk_d        = chk_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;

    if (load) begin
      state_d    = S_HDR_HI;
      len_d      = '0;
      word_idx_d = '0;
      byte_idx_d = '0;
      word_buf_d = '0;
      chk_d      = '0;
    end else if (accept) begin
      unique case (state_q)
        S_HDR_HI: begin
          len_d   = {in_data, len_q[7:0]};
          state_d = S_HDR_LO;
        end
        S_HDR_LO: begin
          len_d = {len_q[15:8], in_data};
          if (len_d == 16'd0 || {1'b0, len_d} > MAX_LEN) state_d = S_ERROR;
          else                                           state_d = S_DATA;
        end
        S_DATA: begin
          chk_d      = chk_q ^ in_data;
          byte_idx_d = byte_idx_q + 2'd1;
          word_buf_d = {word_buf_q[15:0], in_data};
          // Last byte of a word: issue the write next cycle from the registered strobe.
          if (byte_idx_q == 2'd3) begin
            imem_we_d    = 1'b1;
            imem_addr_d  = word_idx_q[ADDR_WIDTH-1:0];
            imem_wdata_d = {word_buf_q, in_data};
            word_idx_d   = word_idx_q + 1'b1;
            if (16'(word_idx_q) == len_q - 16'd1) state_d = S_CHK;
          end
        end
        S_CHK: begin
          state_d = (in_data == chk_q) ? S_RUN : S_ERROR;
        end
        default: ;
      endcase
    end

    cpu_enable_d = (state_d == S_RUN);
    error_d      = (state_d == S_ERROR);
    busy_d       = (state_d == S_HDR_HI) || (state_d == S_HDR_LO) ||
                   (state_d == S_DATA)   || (state_d == S_CHK);
  end

  // NOTE: state is updated only with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_HDR_HI;
      len_q        <= '0;
      word_idx_q   <= '0;
      byte_idx_q   <= '0;
      word_buf_q   <= '0;
      chk_q        <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cpu_enable_q <= 1'b0;
      busy_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      word_idx_q   <= word_idx_d;
      byte_idx_q   <= byte_idx_d;
      word_buf_q   <= word_buf_d;
      chk_q        <= chk_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      cpu_enable_q <= cpu_enable_d;
      busy_q       <= busy_d;
      error_q      <= error_d;
    end
  end

  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign cpu_enable = cpu_enable_q;
  assign busy       = busy_q;
  assign error      = error_q;

endmodule
